// File: rtl/logic_gate_pkg.sv
// ----------------------------------------------------------------------------
// logic_gate_pkg
// Shared definitions for the logic_gate_array pipeline.
//   OP_W  : width of the opcode field carried with every transaction
//   op_e  : opcode encoding for the two-operand bitwise lane function
// ----------------------------------------------------------------------------
package logic_gate_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_NAND = 3'd2,
        OP_NOR  = 3'd3,
        OP_XOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_NOT  = 3'd6,   // ~x1, x2 ignored
        OP_PASS = 3'd7    // x1, x2 ignored
    } op_e;

endpackage

// File: rtl/logic_gate_lane.sv
// ----------------------------------------------------------------------------
// logic_gate_lane
// Combinational WIDTH-bit bitwise logic for one lane.
//   op : opcode selecting the function
//   en : lane enable; a disabled lane always produces zero
//   x1 : operand 1
//   x2 : operand 2
//   y  : result
// ----------------------------------------------------------------------------
module logic_gate_lane
    import logic_gate_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_e              op,
    input  logic             en,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] x2,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        // The enable is applied after the function so that inverting
        // opcodes (NAND/NOR/XNOR/NOT) cannot leak ones out of a masked lane.
        if (en) begin
            case (op)
                OP_AND:  y = x1 & x2;
                OP_OR:   y = x1 | x2;
                OP_NAND: y = ~(x1 & x2);
                OP_NOR:  y = ~(x1 | x2);
                OP_XOR:  y = x1 ^ x2;
                OP_XNOR: y = ~(x1 ^ x2);
                OP_NOT:  y = ~x1;
                OP_PASS: y = x1;
                default: y = '0;
            endcase
        end
    end

endmodule

// File: rtl/logic_gate_array.sv
// ----------------------------------------------------------------------------
// logic_gate_array
// CHANNELS independent lanes of WIDTH-bit bitwise logic behind a two-stage
// valid/ready pipeline, plus a wrapping count of completed output handshakes.
//   clock     : single clock, all state on the rising edge
//   reset     : asynchronous active-low reset
//   in_valid  : input transaction valid
//   in_ready  : pipeline can accept an input this cycle
//   in_op     : opcode (logic_gate_pkg::op_e encoding)
//   in_mask   : per-lane enable, bit c gates lane c
//   in_x1     : operand 1, lane c at [c*WIDTH +: WIDTH]
//   in_x2     : operand 2, same packing
//   out_valid : result valid
//   out_ready : downstream accepts the result
//   out_y     : result, same packing
//   out_op    : opcode that produced out_y
//   txn_count : output handshakes since reset, modulo 2^COUNT_W
// ----------------------------------------------------------------------------
module logic_gate_array
    import logic_gate_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int COUNT_W  = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [OP_W-1:0]           in_op,
    input  logic [CHANNELS-1:0]       in_mask,
    input  logic [CHANNELS*WIDTH-1:0] in_x1,
    input  logic [CHANNELS*WIDTH-1:0] in_x2,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CHANNELS*WIDTH-1:0] out_y,
    output logic [OP_W-1:0]           out_op,
    output logic [COUNT_W-1:0]        txn_count
);

    localparam int DATA_W = CHANNELS * WIDTH;

    // Stage 0: raw operands as accepted from the source
    logic                s0_valid_reg;
    op_e                 s0_op_reg;
    logic [CHANNELS-1:0] s0_mask_reg;
    logic [DATA_W-1:0]   s0_x1_reg;
    logic [DATA_W-1:0]   s0_x2_reg;

    // Stage 1: computed result, drives the outputs directly
    logic                s1_valid_reg;
    op_e                 s1_op_reg;
    logic [DATA_W-1:0]   s1_y_reg;

    logic [COUNT_W-1:0]  count_reg;

    logic                s0_ready;
    logic                s1_ready;
    logic                out_fire;
    logic [DATA_W-1:0]   lane_y;

    // ------------------------------------------------------------------
    // Ready chain. Each stage can take new data when it is empty or when
    // the stage after it is consuming its current contents, so S1 drains
    // and refills in the same cycle without a bubble.
    // ------------------------------------------------------------------
    assign s1_ready = !s1_valid_reg || out_ready;
    assign s0_ready = !s0_valid_reg || s1_ready;
    assign in_ready = s0_ready;
    assign out_fire = s1_valid_reg && out_ready;

    // ------------------------------------------------------------------
    // Lane logic sits between S0 and S1
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
            logic_gate_lane #(
                .WIDTH (WIDTH)
            ) u_lane (
                .op (s0_op_reg),
                .en (s0_mask_reg[gi]),
                .x1 (s0_x1_reg[gi*WIDTH +: WIDTH]),
                .x2 (s0_x2_reg[gi*WIDTH +: WIDTH]),
                .y  (lane_y[gi*WIDTH +: WIDTH])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Stage 0 registers. While S0 can advance, its valid simply follows
    // in_valid, so a source dropping in_valid without a handshake is fine.
    // Payload only loads on a real handshake to keep toggling down.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s0_valid_reg <= 1'b0;
            s0_op_reg    <= OP_AND;
            s0_mask_reg  <= '0;
            s0_x1_reg    <= '0;
            s0_x2_reg    <= '0;
        end else if (s0_ready) begin
            s0_valid_reg <= in_valid;
            if (in_valid) begin
                s0_op_reg   <= op_e'(in_op);
                s0_mask_reg <= in_mask;
                s0_x1_reg   <= in_x1;
                s0_x2_reg   <= in_x2;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1 registers. Result and opcode only change when a new item
    // moves in, so they stay stable while stalled and keep the last value
    // when the pipeline runs empty.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_valid_reg <= 1'b0;
            s1_op_reg    <= OP_AND;
            s1_y_reg     <= '0;
        end else if (s1_ready) begin
            s1_valid_reg <= s0_valid_reg;
            if (s0_valid_reg) begin
                s1_op_reg <= s0_op_reg;
                s1_y_reg  <= lane_y;
            end
        end
    end

    // ------------------------------------------------------------------
    // Completed-transaction counter, wraps silently
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (out_fire) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign out_valid = s1_valid_reg;
    assign out_y     = s1_y_reg;
    assign out_op    = s1_op_reg;
    assign txn_count = count_reg;

endmodule

// File: tb/tb_logic_gate_array.sv
// ----------------------------------------------------------------------------
// tb_logic_gate_array
// Directed bench for logic_gate_array. Three instances cover the default
// configuration, a single-bit NAND configuration and a 2-bit counter.
// ----------------------------------------------------------------------------
module tb_logic_gate_array;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   check_count = 0;
    int   pass_count  = 0;

    always #5 clock = ~clock;

    // main instance: WIDTH=8, CHANNELS=4, COUNT_W=16
    logic        m_in_valid, m_in_ready, m_out_valid, m_out_ready;
    logic [2:0]  m_in_op, m_out_op;
    logic [3:0]  m_in_mask;
    logic [31:0] m_in_x1, m_in_x2, m_out_y;
    logic [15:0] m_txn_count;

    // nand instance: WIDTH=1, CHANNELS=1
    logic        n_in_valid, n_in_ready, n_out_valid, n_out_ready;
    logic [2:0]  n_in_op, n_out_op;
    logic [0:0]  n_in_mask, n_in_x1, n_in_x2, n_out_y;
    logic [15:0] n_txn_count;

    // wrap instance: COUNT_W=2
    logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready;
    logic [2:0]  w_in_op, w_out_op;
    logic [3:0]  w_in_mask;
    logic [31:0] w_in_x1, w_in_x2, w_out_y;
    logic [1:0]  w_txn_count;

    logic_gate_array #(.WIDTH(8), .CHANNELS(4), .COUNT_W(16)) dut (
        .clock(clock), .reset(reset),
        .in_valid(m_in_valid), .in_ready(m_in_ready), .in_op(m_in_op),
        .in_mask(m_in_mask), .in_x1(m_in_x1), .in_x2(m_in_x2),
        .out_valid(m_out_valid), .out_ready(m_out_ready), .out_y(m_out_y),
        .out_op(m_out_op), .txn_count(m_txn_count)
    );

    logic_gate_array #(.WIDTH(1), .CHANNELS(1), .COUNT_W(16)) dut_nand (
        .clock(clock), .reset(reset),
        .in_valid(n_in_valid), .in_ready(n_in_ready), .in_op(n_in_op),
        .in_mask(n_in_mask), .in_x1(n_in_x1), .in_x2(n_in_x2),
        .out_valid(n_out_valid), .out_ready(n_out_ready), .out_y(n_out_y),
        .out_op(n_out_op), .txn_count(n_txn_count)
    );

    logic_gate_array #(.WIDTH(8), .CHANNELS(4), .COUNT_W(2)) dut_wrap (
        .clock(clock), .reset(reset),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_op(w_in_op),
        .in_mask(w_in_mask), .in_x1(w_in_x1), .in_x2(w_in_x2),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_y(w_out_y),
        .out_op(w_out_op), .txn_count(w_txn_count)
    );

    function automatic logic [31:0] item_val(int k);
        return 32'h0101_0101 * 32'(k + 1);
    endfunction

    task automatic apply_reset();
        @(posedge clock); #1;
        reset = 1'b0;
        m_in_valid = 1'b0; n_in_valid = 1'b0; w_in_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        m_in_valid = 1'b1; m_in_op = 3'd7; m_in_mask = 4'hF; m_in_x1 = 32'hDEADBEEF;
        n_in_valid = 1'b1; w_in_valid = 1'b1;
        m_out_ready = 1'b1; n_out_ready = 1'b1; w_out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check_count++;
        if (m_out_valid === 1'b0 && m_txn_count === 16'd0 && m_out_y === 32'd0)
            pass_count++;
        else
            $display("FAIL reset_main: valid=%b count=%0d y=%h required valid=0 count=0 y=0",
                     m_out_valid, m_txn_count, m_out_y);
        check_count++;
        if (n_out_valid === 1'b0 && w_out_valid === 1'b0 && w_txn_count === 2'd0)
            pass_count++;
        else
            $display("FAIL reset_others: nand_valid=%b wrap_valid=%b wrap_count=%0d required 0 0 0",
                     n_out_valid, w_out_valid, w_txn_count);
        m_in_valid = 1'b0; n_in_valid = 1'b0; w_in_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        check_count++;
        if (m_in_ready === 1'b1 && m_out_valid === 1'b0)
            pass_count++;
        else
            $display("FAIL reset_release: in_ready=%b out_valid=%b required 1 0",
                     m_in_ready, m_out_valid);
    endtask

    task automatic test_nand();
        logic exp_y [4];
        exp_y = '{1'b1, 1'b1, 1'b1, 1'b0};
        apply_reset();
        n_out_ready = 1'b1; n_in_mask = 1'b1; n_in_op = 3'd2;
        for (int t = 0; t < 6; t++) begin
            @(posedge clock); #1;
            if (t >= 2) begin
                check_count++;
                if (n_out_valid === 1'b1 && n_out_y[0] === exp_y[t-2] && n_out_op === 3'd2)
                    pass_count++;
                else
                    $display("FAIL nand[%0d]: valid=%b y=%b op=%0d required valid=1 y=%b op=2",
                             t - 2, n_out_valid, n_out_y, n_out_op, exp_y[t-2]);
            end
            if (t < 4) begin
                n_in_valid = 1'b1;
                n_in_x1 = 1'(t >> 1);
                n_in_x2 = 1'(t & 1);
            end else begin
                n_in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_all_ops();
        logic [7:0]  exp_b [8];
        logic [31:0] exp_w;
        exp_b = '{8'hC0, 8'hFC, 8'h3F, 8'h03, 8'h3C, 8'hC3, 8'h0F, 8'hF0};
        apply_reset();
        m_out_ready = 1'b1; m_in_mask = 4'hF;
        m_in_x1 = 32'hF0F0_F0F0; m_in_x2 = 32'hCCCC_CCCC;
        for (int t = 0; t < 10; t++) begin
            @(posedge clock); #1;
            if (t >= 2) begin
                exp_w = {4{exp_b[t-2]}};
                check_count++;
                if (m_out_valid === 1'b1 && m_out_y === exp_w && m_out_op === 3'(t - 2))
                    pass_count++;
                else
                    $display("FAIL all_ops[%0d]: valid=%b y=%h op=%0d required valid=1 y=%h op=%0d",
                             t - 2, m_out_valid, m_out_y, m_out_op, exp_w, t - 2);
            end
            if (t < 8) begin
                m_in_valid = 1'b1;
                m_in_op = 3'(t);
            end else begin
                m_in_valid = 1'b0;
            end
        end
        @(posedge clock); #1;
        check_count++;
        if (m_out_valid === 1'b0 && m_txn_count === 16'd8)
            pass_count++;
        else
            $display("FAIL all_ops_count: valid=%b count=%0d required valid=0 count=8",
                     m_out_valid, m_txn_count);
    endtask

    task automatic test_mask();
        logic [2:0]  v_op   [2];
        logic [3:0]  v_mask [2];
        logic [31:0] v_x    [2];
        logic [31:0] v_exp  [2];
        v_op   = '{3'd3, 3'd5};
        v_mask = '{4'b0101, 4'b1010};
        v_x    = '{32'h0000_0000, 32'h1234_5678};
        v_exp  = '{32'h00FF_00FF, 32'hFF00_FF00};
        apply_reset();
        m_out_ready = 1'b1;
        for (int v = 0; v < 2; v++) begin
            @(posedge clock); #1;
            m_in_valid = 1'b1; m_in_op = v_op[v]; m_in_mask = v_mask[v];
            m_in_x1 = v_x[v]; m_in_x2 = v_x[v];
            @(posedge clock); #1;
            m_in_valid = 1'b0;
            check_count++;
            if (m_out_valid === 1'b0)
                pass_count++;
            else
                $display("FAIL mask_latency[%0d]: out_valid=%b one cycle after accept required 0",
                         v, m_out_valid);
            @(posedge clock); #1;
            check_count++;
            if (m_out_valid === 1'b1 && m_out_y === v_exp[v])
                pass_count++;
            else
                $display("FAIL mask[%0d]: valid=%b y=%h required valid=1 y=%h",
                         v, m_out_valid, m_out_y, v_exp[v]);
        end
    endtask

    task automatic test_backpressure();
        int          next_item = 0;
        int          exp_idx   = 0;
        logic        acc       = 1'b0;
        logic        ofire     = 1'b0;
        logic        held      = 1'b0;
        logic [31:0] held_y    = '0;
        logic        exp_rdy;
        apply_reset();
        m_in_op = 3'd7; m_in_mask = 4'hF; m_in_x2 = '0;
        for (int t = 0; t < 16; t++) begin
            @(posedge clock); #1;
            if (acc) next_item++;
            if (ofire) exp_idx++;
            if (held) begin
                check_count++;
                if (m_out_valid === 1'b1 && m_out_y === held_y)
                    pass_count++;
                else
                    $display("FAIL bp_stable[t=%0d]: valid=%b y=%h required valid=1 y=%h",
                             t, m_out_valid, m_out_y, held_y);
            end
            if (m_out_valid === 1'b1) begin
                check_count++;
                if (exp_idx < 5 && m_out_y === item_val(exp_idx))
                    pass_count++;
                else
                    $display("FAIL bp_order[t=%0d]: y=%h item=%0d required y=%h",
                             t, m_out_y, exp_idx, item_val(exp_idx));
            end
            m_out_ready = !(t >= 3 && t <= 6);
            m_in_valid  = (next_item < 5);
            m_in_x1     = item_val(next_item);
            #1;
            exp_rdy = !(t >= 3 && t <= 6);
            if (t < 12) begin
                check_count++;
                if (m_in_ready === exp_rdy)
                    pass_count++;
                else
                    $display("FAIL bp_in_ready[t=%0d]: in_ready=%b required %b",
                             t, m_in_ready, exp_rdy);
            end
            acc   = m_in_valid && m_in_ready;
            ofire = m_out_valid && m_out_ready;
            held  = m_out_valid && !m_out_ready;
            held_y = m_out_y;
            if (ofire)
                $display("txn t=%0d item=%0d y=%h op=%0d", t, exp_idx, m_out_y, m_out_op);
        end
        check_count++;
        if (exp_idx == 5 && m_txn_count === 16'd5 && m_out_valid === 1'b0)
            pass_count++;
        else
            $display("FAIL bp_done: items_out=%0d count=%0d valid=%b required 5 5 0",
                     exp_idx, m_txn_count, m_out_valid);
    endtask

    task automatic test_wrap_reset();
        apply_reset();
        w_out_ready = 1'b1; w_in_op = 3'd0; w_in_mask = 4'hF;
        w_in_x1 = 32'hFFFF_FFFF; w_in_x2 = 32'h0F0F_0F0F;
        for (int t = 0; t < 9; t++) begin
            @(posedge clock); #1;
            w_in_valid = (t < 5);
        end
        check_count++;
        if (w_txn_count === 2'd1 && w_out_valid === 1'b0)
            pass_count++;
        else
            $display("FAIL wrap_count: count=%0d valid=%b required count=1 valid=0",
                     w_txn_count, w_out_valid);
        // two items in flight, then reset
        w_out_ready = 1'b0;
        for (int t = 0; t < 2; t++) begin
            @(posedge clock); #1;
            w_in_valid = 1'b1;
        end
        @(posedge clock); #1;
        w_in_valid = 1'b0;
        @(posedge clock); #1;
        check_count++;
        if (w_out_valid === 1'b1 && w_in_ready === 1'b0)
            pass_count++;
        else
            $display("FAIL wrap_inflight: valid=%b in_ready=%b required valid=1 in_ready=0",
                     w_out_valid, w_in_ready);
        reset = 1'b0;
        #1;
        check_count++;
        if (w_out_valid === 1'b0 && w_txn_count === 2'd0)
            pass_count++;
        else
            $display("FAIL wrap_async_reset: valid=%b count=%0d required 0 0",
                     w_out_valid, w_txn_count);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        w_out_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            @(posedge clock); #1;
            check_count++;
            if (w_out_valid === 1'b0 && w_txn_count === 2'd0)
                pass_count++;
            else
                $display("FAIL wrap_flushed[%0d]: valid=%b count=%0d required 0 0",
                         t, w_out_valid, w_txn_count);
        end
    endtask

    initial begin
        m_in_valid = 1'b0; m_out_ready = 1'b1; m_in_op = '0; m_in_mask = '0;
        m_in_x1 = '0; m_in_x2 = '0;
        n_in_valid = 1'b0; n_out_ready = 1'b1; n_in_op = '0; n_in_mask = '0;
        n_in_x1 = '0; n_in_x2 = '0;
        w_in_valid = 1'b0; w_out_ready = 1'b1; w_in_op = '0; w_in_mask = '0;
        w_in_x1 = '0; w_in_x2 = '0;

        test_reset();
        test_nand();
        test_all_ops();
        test_mask();
        test_backpressure();
        test_wrap_reset();

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
